// File: rtl/adler32_checksum.sv
// Streaming Adler-32 (RFC 1950) engine: a size strobe, then size contiguous bytes, then a
// one-cycle checksum strobe. fsm_state exposes the controller state for observation.
module adler32_checksum (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        size_valid,
   input  logic [31:0] size,
   input  logic        data_start,
   input  logic [7:0]  data,
   output logic        checksum_valid,
   output logic [31:0] checksum,
   output logic [1:0]  fsm_state
);

   // Strobe protocol: size_valid is honoured only in IDLE; data_start only in IDLE (same cycle
   // as size_valid) or WAIT; once the first byte is taken, data is sampled every cycle with no
   // qualifier until the count reaches zero; checksum_valid is high for exactly one cycle.

   localparam logic [16:0] MOD = 17'd65521;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state, state_d;
   logic [15:0] a, b;
   logic [31:0] remaining;
   logic        load, consume;

   logic [15:0] op_a, op_b, a_new, b_new, a_fin, b_fin;
   logic [16:0] a_sum, b_sum;
   logic [31:0] cnt_src;

   assign fsm_state = state;

   // A fresh message starts from A=1, B=0 even when its first byte arrives with size_valid.
   assign op_a    = load ? 16'd1 : a;
   assign op_b    = load ? 16'd0 : b;
   assign cnt_src = load ? size : remaining;

   assign a_sum = {1'b0, op_a} + {9'd0, data};
   assign a_new = (a_sum >= MOD) ? 16'(a_sum - MOD) : a_sum[15:0];
   assign b_sum = {1'b0, op_b} + {1'b0, a_new};
   assign b_new = (b_sum >= MOD) ? 16'(b_sum - MOD) : b_sum[15:0];

   assign a_fin = consume ? a_new : op_a;
   assign b_fin = consume ? b_new : op_b;

   always_comb begin
      state_d = state;
      load    = 1'b0;
      consume = 1'b0;
      case (state)
         IDLE: begin
            if (size_valid) begin
               load = 1'b1;
               if (size == 32'd0) begin
                  state_d = DONE;
               end else if (data_start) begin
                  consume = 1'b1;
                  state_d = (size == 32'd1) ? DONE : DATA;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (data_start) begin
               consume = 1'b1;
               state_d = (remaining == 32'd1) ? DONE : DATA;
            end
         end
         DATA: begin
            consume = 1'b1;
            state_d = (remaining == 32'd1) ? DONE : DATA;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         a              <= 16'd1;
         b              <= 16'd0;
         remaining      <= 32'd0;
         checksum_valid <= 1'b0;
         checksum       <= 32'd0;
      end else begin
         if (load || consume) begin
            a         <= a_fin;
            b         <= b_fin;
            remaining <= consume ? cnt_src - 32'd1 : cnt_src;
         end else if (state == DONE) begin
            a <= 16'd1;
            b <= 16'd0;
         end
         // Result is captured on entry to DONE so it is stable for the whole strobe cycle.
         checksum_valid <= (state_d == DONE) && (state != DONE);
         if ((state_d == DONE) && (state != DONE)) begin
            checksum <= {b_fin, a_fin};
         end
      end
   end

endmodule

// File: tb/tb_adler32_checksum.sv
// Directed bench for adler32_checksum: drives messages through a driver task and checks each
// checksum strobe against hand-computed Adler-32 values held in an expected queue.
module tb_adler32_checksum;

   logic        clock;
   logic        rst_n;
   logic        size_valid;
   logic [31:0] size;
   logic        data_start;
   logic [7:0]  data;
   logic        checksum_valid;
   logic [31:0] checksum;
   logic [1:0]  fsm_state;

   logic [31:0] exp_q[$];
   logic [7:0]  msg[$];
   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;
   int          pulses_mark;

   adler32_checksum dut (
      .clock          (clock),
      .rst_n          (rst_n),
      .size_valid     (size_valid),
      .size           (size),
      .data_start     (data_start),
      .data           (data),
      .checksum_valid (checksum_valid),
      .checksum       (checksum),
      .fsm_state      (fsm_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (checksum_valid === 1'b1) pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver: size strobe, then gap idle cycles, then the bytes of msg contiguously
   task automatic send_msg(input int gap);
      int n;
      n = msg.size();
      @(posedge clock); #1;
      size_valid = 1'b1;
      size       = 32'(n);
      if (n == 0) begin
         @(posedge clock); #1;
         size_valid = 1'b0;
         return;
      end
      for (int i = 0; i < gap; i++) begin
         @(posedge clock); #1;
         size_valid = 1'b0;
      end
      data_start = 1'b1;
      data       = msg[0];
      for (int i = 1; i < n; i++) begin
         @(posedge clock); #1;
         size_valid = 1'b0;
         data_start = 1'b0;
         data       = msg[i];
      end
      @(posedge clock); #1;
      size_valid = 1'b0;
      data_start = 1'b0;
      data       = 8'h00;
   endtask

   // scoreboard: the strobe must be up in the cycle right after the last byte, then drop
   task automatic check_result(input string tag);
      logic [31:0] exp;
      exp = exp_q.pop_front();
      @(negedge clock);
      check({tag, "_valid"}, 32'(checksum_valid), 32'd1);
      check({tag, "_sum"}, checksum, exp);
      @(negedge clock);
      check({tag, "_valid_drop"}, 32'(checksum_valid), 32'd0);
      check({tag, "_hold"}, checksum, exp);
   endtask

   task automatic load_wiki();
      msg = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
   endtask

   task automatic load_fill(input int n, input logic [7:0] v);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(v);
   endtask

   initial begin
      rst_n      = 1'b0;
      size_valid = 1'b0;
      size       = 32'd0;
      data_start = 1'b0;
      data       = 8'h00;
      repeat (3) @(negedge clock);
      check("reset_valid", 32'(checksum_valid), 32'd0);
      check("reset_sum", checksum, 32'd0);
      check("reset_state", 32'(fsm_state), 32'd0);
      @(posedge clock); #1;
      rst_n = 1'b1;

      // "Wikipedia", data_start one cycle after size_valid
      load_wiki();
      exp_q.push_back(32'h11E60398);
      pulses_mark = pulses;
      send_msg(1);
      check_result("wiki");
      #1;
      check("wiki_pulses", 32'(pulses - pulses_mark), 32'd1);

      // back to back: "a", then "abc" two cycles after the first strobe
      pulses_mark = pulses;
      msg = '{8'h61};
      exp_q.push_back(32'h00620062);
      send_msg(0);
      @(negedge clock);
      check("b2b_a_valid", 32'(checksum_valid), 32'd1);
      check("b2b_a_sum", checksum, exp_q.pop_front());
      msg = '{8'h61, 8'h62, 8'h63};
      exp_q.push_back(32'h024D0127);
      send_msg(0);
      check_result("b2b_abc");
      #1;
      check("b2b_pulses", 32'(pulses - pulses_mark), 32'd2);

      // empty message
      msg.delete();
      exp_q.push_back(32'h00000001);
      send_msg(0);
      check_result("empty");

      // 1024 zero bytes: A stays 1, B = 1024
      load_fill(1024, 8'h00);
      exp_q.push_back(32'h04000001);
      send_msg(2);
      check_result("zeros1024");

      // 300 x 0xFF: A = 76501 mod 65521 = 10980, B = 11513550 mod 65521 = 47375
      load_fill(300, 8'hFF);
      exp_q.push_back(32'hB90F2AE4);
      send_msg(1);
      check_result("ff300");

      // "a" with size_valid and data_start together, then with a 5-cycle gap
      msg = '{8'h61};
      exp_q.push_back(32'h00620062);
      send_msg(0);
      check_result("a_same");
      exp_q.push_back(32'h00620062);
      send_msg(5);
      check_result("a_gap5");

      // stray data_start in IDLE must not start anything
      pulses_mark = pulses;
      @(posedge clock); #1;
      data_start = 1'b1;
      data       = 8'h55;
      @(posedge clock); #1;
      data_start = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      check("stray_start_pulses", 32'(pulses - pulses_mark), 32'd0);
      check("stray_start_state", 32'(fsm_state), 32'd0);

      // reset in the middle of "Wikipedia"
      load_wiki();
      pulses_mark = pulses;
      @(posedge clock); #1;
      size_valid = 1'b1;
      size       = 32'd9;
      data_start = 1'b1;
      data       = msg[0];
      for (int i = 1; i < 4; i++) begin
         @(posedge clock); #1;
         size_valid = 1'b0;
         data_start = 1'b0;
         data       = msg[i];
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid", 32'(checksum_valid), 32'd0);
      check("abort_sum", checksum, 32'd0);
      check("abort_state", 32'(fsm_state), 32'd0);
      @(posedge clock); #1;
      data = 8'h00;
      @(posedge clock); #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clock);
      #1;
      check("abort_pulses", 32'(pulses - pulses_mark), 32'd0);
      check("abort_sum_after", checksum, 32'd0);

      msg = '{8'h61};
      exp_q.push_back(32'h00620062);
      send_msg(1);
      check_result("after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // overall time limit
   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("Result: errors=%0d of %0d checks", errors, checks + 1);
      $fatal(1, "time limit reached");
   end

endmodule
